// File: rtl/fire6_squeeze_bias_relu_if.sv
// ---------------------------------------------------------------------------
// fire6_squeeze_bias_relu_if
//   Stream bundle for the fire6 squeeze bias/ReLU/requantize stage.
//   Input side : acc_data / acc_valid / acc_ready (one accumulator per channel)
//   Output side: out_data / out_ch / out_last / out_valid / out_ready,
//                plus the frame_done pulse.
//   Modports:
//     slave  - the processing stage (consumes accumulators, produces outputs)
//     master - the environment around it (producer upstream, sink downstream)
// ---------------------------------------------------------------------------
interface fire6_squeeze_bias_relu_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int CH_W  = 6
);
  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_ready;
  logic [OUT_W-1:0] out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             frame_done;

  modport slave (
    input  acc_data, acc_valid, out_ready,
    output acc_ready, out_data, out_ch, out_last, out_valid, frame_done
  );

  modport master (
    output acc_data, acc_valid, out_ready,
    input  acc_ready, out_data, out_ch, out_last, out_valid, frame_done
  );
endinterface

// File: rtl/fire6_squeeze_bias_relu.sv
// ---------------------------------------------------------------------------
// fire6_squeeze_bias_relu
//   Post-accumulation stage of the fire6 squeeze layer. For every incoming
//   accumulator it adds the bias of the current channel, applies ReLU,
//   requantizes with an arithmetic right shift by SHIFT and saturates to the
//   positive range of a signed OUT_W container.
//   Two-stage stallable valid/ready pipeline:
//     stage 1 : bias add (33-bit, cannot overflow) + channel/pixel tagging
//     stage 2 : ReLU, shift, saturation -> output register
//   Ports:
//     clk      - clock
//     rst      - synchronous active-high reset
//     bias_mem - per-channel bias array, static after reset
//     bus      - slave side of the stream bundle (accumulators in,
//                activations out, frame_done pulse)
// ---------------------------------------------------------------------------
module fire6_squeeze_bias_relu #(
  parameter int NUM_CH     = 64,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int NUM_PIXELS = 169,
  localparam int CH_W      = $clog2(NUM_CH),
  localparam int PIX_W     = $clog2(NUM_PIXELS),
  localparam int SUM_W     = ACC_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] bias_mem [0:NUM_CH-1],
  fire6_squeeze_bias_relu_if.slave bus
);

  // Largest positive value of the signed output container, widened so it can
  // be compared against the shifted sum directly.
  localparam logic [OUT_W-1:0] OUT_MAX      = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] OUT_MAX_WIDE = {{(SUM_W-OUT_W){1'b0}}, OUT_MAX};

  // ---------------- position counters ----------------
  logic [CH_W-1:0]  ch_cnt_q,  ch_cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;

  // ---------------- stage 1 ----------------
  logic             s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0] s1_sum_q,   s1_sum_d;
  logic [CH_W-1:0]  s1_ch_q;
  logic             s1_last_q,  s1_last_d;
  logic             s1_eof_q,   s1_eof_d;

  // ---------------- stage 2 (output) ----------------
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_last_q;
  logic             eof_q;
  logic             frame_done_q, frame_done_d;

  // ---------------- handshakes ----------------
  logic acc_ready;
  logic in_xfer;
  logic s1_advance;
  logic s1_load;
  logic out_xfer;
  logic ch_wrap;
  logic pix_wrap;

  // Stage 1 may move forward whenever stage 2 is empty or being drained this
  // cycle; the input is accepted whenever stage 1 is empty or moving forward.
  // Keeping this combinational is what allows one transfer per cycle.
  assign s1_advance = !out_valid_q || bus.out_ready;
  assign acc_ready  = !s1_valid_q || s1_advance;
  assign in_xfer    = bus.acc_valid && acc_ready;
  assign s1_load    = s1_valid_q && s1_advance;
  assign out_xfer   = out_valid_q && bus.out_ready;

  assign ch_wrap  = (ch_cnt_q  == CH_W'(NUM_CH - 1));
  assign pix_wrap = (pix_cnt_q == PIX_W'(NUM_PIXELS - 1));

  // ---------------- counters next state ----------------
  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    if (in_xfer) begin
      if (ch_wrap) begin
        ch_cnt_d  = '0;
        pix_cnt_d = pix_wrap ? '0 : pix_cnt_q + 1'b1;
      end else begin
        ch_cnt_d  = ch_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- stage 1 next state ----------------
  // Bias lookup and tags use the pre-increment channel counter.
  always_comb begin
    s1_sum_d  = {bus.acc_data[ACC_W-1], bus.acc_data}
              + {bias_mem[ch_cnt_q][ACC_W-1], bias_mem[ch_cnt_q]};
    s1_last_d = ch_wrap;
    s1_eof_d  = ch_wrap && pix_wrap;

    s1_valid_d = s1_valid_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------- stage 2 datapath ----------------
  logic [SUM_W-1:0] relu_val;
  logic [SUM_W-1:0] shifted_val;

  always_comb begin
    // A negative sum is clamped before shifting, so the shift below only
    // ever sees non-negative values and a logical shift is exact.
    relu_val    = s1_sum_q[SUM_W-1] ? '0 : s1_sum_q;
    shifted_val = relu_val >> SHIFT;
    if (shifted_val > OUT_MAX_WIDE) begin
      out_data_d = OUT_MAX;
    end else begin
      out_data_d = shifted_val[OUT_W-1:0];
    end

    out_valid_d = out_valid_q;
    if (s1_load) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // The pulse lands in the cycle after the end-of-frame output is taken.
    frame_done_d = out_xfer && eof_q;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q     <= '0;
      pix_cnt_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_ch_q      <= '0;
      s1_last_q    <= 1'b0;
      s1_eof_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_last_q   <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ch_cnt_q     <= ch_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;

      if (in_xfer) begin
        s1_sum_q  <= s1_sum_d;
        s1_ch_q   <= ch_cnt_q;
        s1_last_q <= s1_last_d;
        s1_eof_q  <= s1_eof_d;
      end

      // Output registers only change when stage 1 moves forward, which keeps
      // them stable while the downstream side stalls.
      if (s1_load) begin
        out_data_q <= out_data_d;
        out_ch_q   <= s1_ch_q;
        out_last_q <= s1_last_q;
        eof_q      <= s1_eof_q;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.acc_ready  = acc_ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fire6_squeeze_bias_relu.sv
// ---------------------------------------------------------------------------
// tb_fire6_squeeze_bias_relu
//   Self-checking bench for fire6_squeeze_bias_relu (SHIFT = 4).
//   Expected activations come from a plain-arithmetic reference model fed by
//   every accepted input and consumed in order by every accepted output.
// ---------------------------------------------------------------------------
module tb_fire6_squeeze_bias_relu;

  localparam int NUM_CH     = 64;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 4;
  localparam int NUM_PIXELS = 169;
  localparam int CH_W       = 6;
  localparam int FRAME      = NUM_CH * NUM_PIXELS;
  localparam int STIM_N     = 16384;

  logic clk = 1'b0;
  logic rst;
  logic [ACC_W-1:0] bias_mem [0:NUM_CH-1];

  always #5 clk = ~clk;

  fire6_squeeze_bias_relu_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CH_W(CH_W)) bus ();

  fire6_squeeze_bias_relu #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .SHIFT(SHIFT), .NUM_PIXELS(NUM_PIXELS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bias_mem(bias_mem),
    .bus(bus)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [OUT_W-1:0] model(input int acc, input int b);
    longint s;
    s = longint'(acc) + longint'(b);
    if (s < 0) s = 0;
    s = s / (longint'(1) << SHIFT);
    if (s > 32767) s = 32767;
    return OUT_W'(s);
  endfunction

  int stim [0:STIM_N-1];

  // ---------------- bench state ----------------
  bit  drive_en   = 1'b0;
  bit  gaps       = 1'b0;
  bit  strict     = 1'b0;
  int  ready_mode = 0;

  int  sent_cnt   = 0;
  int  fd_pulses  = 0;
  bit  fd_exp     = 1'b0;
  bit  first_out  = 1'b1;
  bit  after_rst  = 1'b0;
  longint cyc = 0;
  longint last_out_cyc = 0;

  logic [OUT_W-1:0] q_data [$];
  int               q_ch   [$];
  bit               q_last [$];
  bit               q_eof  [$];
  int               q_idx  [$];

  // ---------------- driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.acc_valid = drive_en && (!gaps || ($urandom_range(3) != 0));
      bus.acc_data  = stim[sent_cnt % STIM_N];
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q_data.delete(); q_ch.delete(); q_last.delete(); q_eof.delete(); q_idx.delete();
        sent_cnt  = 0;
        fd_exp    = 1'b0;
        first_out = 1'b1;
        after_rst = 1'b1;
      end else begin
        check("frame_done", 64'(bus.frame_done), 64'(fd_exp));
        fd_exp = 1'b0;
        if (bus.frame_done === 1'b1) fd_pulses++;

        if (strict && bus.acc_valid) check("t4_acc_ready", 64'(bus.acc_ready), 64'd1);

        if (bus.acc_valid && bus.acc_ready) begin
          int ch, pix;
          ch  = sent_cnt % NUM_CH;
          pix = (sent_cnt / NUM_CH) % NUM_PIXELS;
          q_data.push_back(model(int'($signed(bus.acc_data)), int'($signed(bias_mem[ch]))));
          q_ch.push_back(ch);
          q_last.push_back(ch == NUM_CH - 1);
          q_eof.push_back((ch == NUM_CH - 1) && (pix == NUM_PIXELS - 1));
          q_idx.push_back(sent_cnt);
          sent_cnt++;
        end

        if (bus.out_valid && bus.out_ready) begin
          if (q_data.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
          end else begin
            logic [OUT_W-1:0] d;
            int c, idx;
            bit l, e;
            d = q_data.pop_front(); c = q_ch.pop_front(); l = q_last.pop_front();
            e = q_eof.pop_front();  idx = q_idx.pop_front();
            check("out_data", 64'(bus.out_data), 64'(d));
            check("out_ch", 64'(bus.out_ch), 64'(c));
            check("out_last", 64'(bus.out_last), 64'(l));
            if (idx == 34)  check("t3_saturate", 64'(bus.out_data), 64'd32767);
            if (idx == 64)  check("t2_relu", 64'(bus.out_data), 64'd0);
            if (idx == 128) check("t2_min_neg", 64'(bus.out_data), 64'd0);
            if (idx == 127) check("t_max_sum_sat", 64'(bus.out_data), 64'd32767);
            if (e) fd_exp = 1'b1;
          end
          if (after_rst) begin
            check("t6_restart_ch", 64'(bus.out_ch), 64'd0);
            after_rst = 1'b0;
          end
          if (strict && !first_out) check("t4_gap", 64'(cyc - last_out_cyc), 64'd1);
          first_out    = 1'b0;
          last_out_cyc = cyc;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_sent(input int target, input int limit, input string tag);
    int n = 0;
    while (sent_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sent_cnt < target) check(tag, 64'(sent_cnt), 64'(target));
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int n = 0;
    while ((q_data.size() != 0 || bus.out_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(q_data.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt, accepted;
    logic [OUT_W-1:0] held_data;
    logic [CH_W-1:0]  held_ch;

    rst = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < NUM_CH; i++) bias_mem[i] = ACC_W'(int'($urandom_range(131071)) - 65536);
    bias_mem[0]  = ACC_W'(-18);
    bias_mem[34] = ACC_W'(1344);
    bias_mem[62] = 32'h8000_0000;
    bias_mem[63] = 32'h7fff_ffff;

    for (int i = 0; i < STIM_N; i++) begin
      if ($urandom_range(3) == 0) stim[i] = int'($urandom);
      else                        stim[i] = int'($urandom_range(4194303)) - 2097152;
    end
    stim[0]   = 100;           // ch0 pix0: (100-18)>>4 = 5
    stim[34]  = 1048576;       // ch34 pix0: 1049920>>4 = 65620 -> saturate
    stim[64]  = 10;            // ch0 pix1: sum -8 -> 0
    stim[126] = int'(32'h8000_0000); // ch62: -2^32, must not wrap positive
    stim[127] = int'(32'h7fff_ffff); // ch63: 2^32-2, must not wrap negative
    stim[128] = int'(32'h8000_0000); // ch0 pix2: most negative accumulator

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ch", 64'(bus.out_ch), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_acc_ready", 64'(bus.acc_ready), 64'd1);

    // Test 1: first transfer and its latency; stream 4 pixels back-to-back
    strict   = 1'b1;
    drive_en = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(bus.acc_valid && bus.acc_ready) && cnt < 20);
    if (cnt >= 20) check("t1_xfer_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("t1_lat_cycle1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("t1_lat_cycle2", 64'(bus.out_valid), 64'd1);
    check("t1_data", 64'(bus.out_data), 64'd5);
    check("t1_ch", 64'(bus.out_ch), 64'd0);
    check("t1_last", 64'(bus.out_last), 64'd0);

    wait_sent(4 * NUM_CH, 2000, "t4_sent_timeout");
    strict   = 1'b0;
    drive_en = 1'b0;
    wait_drain(200, "t4_drain");

    // Test 5: downstream stall on an empty pipeline
    ready_mode = 2;
    drive_en   = 1'b1;
    accepted   = 0;
    held_data  = '0;
    held_ch    = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.acc_valid && bus.acc_ready) accepted++;
      if (k == 3) begin
        check("t5_out_valid", 64'(bus.out_valid), 64'd1);
        held_data = bus.out_data;
        held_ch   = bus.out_ch;
      end
      if (k > 3) begin
        check("t5_hold_data", 64'(bus.out_data), 64'(held_data));
        check("t5_hold_ch", 64'(bus.out_ch), 64'(held_ch));
      end
    end
    check("t5_accepted", 64'(accepted), 64'd2);
    check("t5_ready_low", 64'(bus.acc_ready), 64'd0);
    ready_mode = 0;

    // Test 6: rest of the frame with random gaps and backpressure
    ready_mode = 1;
    gaps       = 1'b1;
    wait_sent(FRAME, 60000, "t6_frame_timeout");
    wait_sent(FRAME + 50 * NUM_CH + 10, 30000, "t6_pix50_timeout");
    check("t6_fd_count", 64'(fd_pulses), 64'd1);

    // Reset in the middle of the second frame
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);

    wait_sent(3 * NUM_CH, 3000, "t6_restart_timeout");
    drive_en   = 1'b0;
    ready_mode = 0;
    wait_drain(300, "t6_drain");
    check("t6_no_abort_fd", 64'(fd_pulses), 64'd1);
    check("t6_restart_seen", 64'(after_rst), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
